// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: operand forwarding, ALU, branch resolve, EX/MEM register
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [2:0]      ex_alu_control,
  input  logic            ex_alu_src,
  input  logic [XLEN-1:0] ex_rd1,
  input  logic [XLEN-1:0] ex_rd2,
  input  logic [XLEN-1:0] ex_imm_ext,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_pc_plus4,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_write,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic [1:0]      ex_result_src,
  input  logic [1:0]      fwd_a,
  input  logic [1:0]      fwd_b,
  input  logic [XLEN-1:0] wb_result,
  input  logic            stall_m,
  output logic            pc_src_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic            mem_valid,
  output logic            mem_reg_write,
  output logic            mem_mem_write,
  output logic [1:0]      mem_result_src,
  output logic [XLEN-1:0] mem_alu_result,
  output logic [XLEN-1:0] mem_write_data,
  output logic [XLEN-1:0] mem_pc_plus4,
  output logic [4:0]      mem_rd
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // EX/MEM pipeline register state
  logic            mem_valid_q,      mem_valid_d;
  logic            mem_reg_write_q,  mem_reg_write_d;
  logic            mem_mem_write_q,  mem_mem_write_d;
  logic [1:0]      mem_result_src_q, mem_result_src_d;
  logic [XLEN-1:0] mem_alu_result_q, mem_alu_result_d;
  logic [XLEN-1:0] mem_write_data_q, mem_write_data_d;
  logic [XLEN-1:0] mem_pc_plus4_q,   mem_pc_plus4_d;
  logic [4:0]      mem_rd_q,         mem_rd_d;

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b_val;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            slt_lt;
  logic            zero;

  // Forwarding muxes; the MEM path uses the registered result, never the live ALU output
  always_comb begin
    src_a     = ex_rd1;
    fwd_b_val = ex_rd2;
    case (fwd_a)
      FWD_WB:  src_a = wb_result;
      FWD_MEM: src_a = mem_alu_result_q;
      default: src_a = ex_rd1;
    endcase
    case (fwd_b)
      FWD_WB:  fwd_b_val = wb_result;
      FWD_MEM: fwd_b_val = mem_alu_result_q;
      default: fwd_b_val = ex_rd2;
    endcase
  end

  assign src_b  = ex_alu_src ? ex_imm_ext : fwd_b_val;
  assign slt_lt = $signed(src_a) < $signed(src_b);

  // ALU; unused opcodes produce zero so stray encodings are harmless downstream
  always_comb begin
    alu_result = '0;
    case (ex_alu_control)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, slt_lt};
      default: alu_result = '0;
    endcase
  end

  assign zero        = (alu_result == '0);
  assign pc_src_e    = ex_valid & (ex_jump | (ex_branch & zero));
  assign pc_target_e = ex_pc + ex_imm_ext;

  // EX/MEM next state: hold on stall, clear on bubble, otherwise capture this instruction
  always_comb begin
    mem_valid_d      = mem_valid_q;
    mem_reg_write_d  = mem_reg_write_q;
    mem_mem_write_d  = mem_mem_write_q;
    mem_result_src_d = mem_result_src_q;
    mem_alu_result_d = mem_alu_result_q;
    mem_write_data_d = mem_write_data_q;
    mem_pc_plus4_d   = mem_pc_plus4_q;
    mem_rd_d         = mem_rd_q;
    if (!stall_m) begin
      if (ex_valid) begin
        mem_valid_d      = 1'b1;
        mem_reg_write_d  = ex_reg_write;
        mem_mem_write_d  = ex_mem_write;
        mem_result_src_d = ex_result_src;
        mem_alu_result_d = alu_result;
        mem_write_data_d = fwd_b_val;
        mem_pc_plus4_d   = ex_pc_plus4;
        mem_rd_d         = ex_rd;
      end else begin
        mem_valid_d      = 1'b0;
        mem_reg_write_d  = 1'b0;
        mem_mem_write_d  = 1'b0;
        mem_result_src_d = '0;
        mem_alu_result_d = '0;
        mem_write_data_d = '0;
        mem_pc_plus4_d   = '0;
        mem_rd_d         = '0;
      end
    end
  end

  // EX/MEM register; reset wins over stall and valid
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q      <= 1'b0;
      mem_reg_write_q  <= 1'b0;
      mem_mem_write_q  <= 1'b0;
      mem_result_src_q <= '0;
      mem_alu_result_q <= '0;
      mem_write_data_q <= '0;
      mem_pc_plus4_q   <= '0;
      mem_rd_q         <= '0;
    end else begin
      mem_valid_q      <= mem_valid_d;
      mem_reg_write_q  <= mem_reg_write_d;
      mem_mem_write_q  <= mem_mem_write_d;
      mem_result_src_q <= mem_result_src_d;
      mem_alu_result_q <= mem_alu_result_d;
      mem_write_data_q <= mem_write_data_d;
      mem_pc_plus4_q   <= mem_pc_plus4_d;
      mem_rd_q         <= mem_rd_d;
    end
  end

  assign mem_valid      = mem_valid_q;
  assign mem_reg_write  = mem_reg_write_q;
  assign mem_mem_write  = mem_mem_write_q;
  assign mem_result_src = mem_result_src_q;
  assign mem_alu_result = mem_alu_result_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_pc_plus4   = mem_pc_plus4_q;
  assign mem_rd         = mem_rd_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage
module tb_ex_stage;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic [2:0]  ex_alu_control;
  logic        ex_alu_src;
  logic [31:0] ex_rd1, ex_rd2, ex_imm_ext, ex_pc, ex_pc_plus4;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_write, ex_branch, ex_jump;
  logic [1:0]  ex_result_src;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] wb_result;
  logic        stall_m;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic        mem_valid, mem_reg_write, mem_mem_write;
  logic [1:0]  mem_result_src;
  logic [31:0] mem_alu_result, mem_write_data, mem_pc_plus4;
  logic [4:0]  mem_rd;

  int n_cmp = 0;
  int n_fail = 0;

  ex_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_alu_control(ex_alu_control),
    .ex_alu_src(ex_alu_src), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm_ext(ex_imm_ext),
    .ex_pc(ex_pc), .ex_pc_plus4(ex_pc_plus4), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_result_src(ex_result_src), .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_result(wb_result),
    .stall_m(stall_m), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
    .mem_result_src(mem_result_src), .mem_alu_result(mem_alu_result),
    .mem_write_data(mem_write_data), .mem_pc_plus4(mem_pc_plus4), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    reset = 1'b0; ex_valid = 1'b0; ex_alu_control = 3'b000; ex_alu_src = 1'b0;
    ex_rd1 = '0; ex_rd2 = '0; ex_imm_ext = '0; ex_pc = '0; ex_pc_plus4 = '0; ex_rd = '0;
    ex_reg_write = 1'b0; ex_mem_write = 1'b0; ex_branch = 1'b0; ex_jump = 1'b0;
    ex_result_src = 2'b00; fwd_a = 2'b00; fwd_b = 2'b00; wb_result = '0; stall_m = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1; stall_m = 1'b1; ex_valid = 1'b1; ex_reg_write = 1'b1; ex_rd1 = 32'd9;
    ex_alu_src = 1'b1; ex_imm_ext = 32'd1; ex_rd = 5'd3;
    tick();
    n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", mem_valid); end
    n_cmp++; if (mem_reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_reg_write: got %b exp 0", mem_reg_write); end
    n_cmp++; if (mem_alu_result !== 32'd0) begin n_fail++; $display("FAIL reset_alu: got %h exp 0", mem_alu_result); end
    n_cmp++; if (mem_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %h exp 0", mem_rd); end
    ex_valid = 1'b0; ex_jump = 1'b1;
    #1;
    n_cmp++; if (pc_src_e !== 1'b0) begin n_fail++; $display("FAIL reset_pc_src: got %b exp 0", pc_src_e); end
    set_idle();
  endtask

  task automatic test_add();
    set_idle();
    ex_valid = 1'b1; ex_rd1 = 32'd5; ex_imm_ext = 32'd7; ex_alu_src = 1'b1; ex_rd2 = 32'h55;
    ex_rd = 5'd3; ex_reg_write = 1'b1; ex_result_src = 2'b10; ex_pc_plus4 = 32'h104;
    tick();
    n_cmp++; if (mem_alu_result !== 32'd12) begin n_fail++; $display("FAIL add_result: got %h exp %h", mem_alu_result, 32'd12); end
    n_cmp++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b exp 1", mem_valid); end
    n_cmp++; if (mem_write_data !== 32'h55) begin n_fail++; $display("FAIL add_wdata: got %h exp 55", mem_write_data); end
    n_cmp++; if (mem_rd !== 5'd3) begin n_fail++; $display("FAIL add_rd: got %h exp 3", mem_rd); end
    n_cmp++; if (mem_reg_write !== 1'b1) begin n_fail++; $display("FAIL add_reg_write: got %b exp 1", mem_reg_write); end
    n_cmp++; if (mem_result_src !== 2'b10) begin n_fail++; $display("FAIL add_result_src: got %b exp 10", mem_result_src); end
    n_cmp++; if (mem_pc_plus4 !== 32'h104) begin n_fail++; $display("FAIL add_pc4: got %h exp 104", mem_pc_plus4); end
  endtask

  task automatic test_forward_sub();
    set_idle();
    ex_valid = 1'b1; ex_rd1 = 32'd20; ex_alu_src = 1'b1; ex_imm_ext = 32'd0;
    tick();
    ex_alu_src = 1'b0; fwd_a = 2'b10; ex_rd1 = 32'd999; ex_rd2 = 32'd20; ex_alu_control = 3'b001;
    ex_branch = 1'b1; ex_pc = 32'h100; ex_imm_ext = 32'h40;
    #1;
    n_cmp++; if (pc_src_e !== 1'b1) begin n_fail++; $display("FAIL fwd_mem_pc_src: got %b exp 1", pc_src_e); end
    n_cmp++; if (pc_target_e !== 32'h140) begin n_fail++; $display("FAIL fwd_pc_target: got %h exp 140", pc_target_e); end
    fwd_a = 2'b11;
    #1;
    n_cmp++; if (pc_src_e !== 1'b0) begin n_fail++; $display("FAIL fwd_code11_pc_src: got %b exp 0", pc_src_e); end
    fwd_a = 2'b01; wb_result = 32'd20;
    #1;
    n_cmp++; if (pc_src_e !== 1'b1) begin n_fail++; $display("FAIL fwd_wb_pc_src: got %b exp 1", pc_src_e); end
    fwd_a = 2'b10;
    tick();
    n_cmp++; if (mem_alu_result !== 32'd0) begin n_fail++; $display("FAIL fwd_sub_result: got %h exp 0", mem_alu_result); end
    n_cmp++; if (mem_write_data !== 32'd20) begin n_fail++; $display("FAIL fwd_sub_wdata: got %h exp 14", mem_write_data); end
  endtask

  task automatic test_alu_ops();
    logic [2:0]  t_ctrl [11];
    logic [31:0] t_a [11];
    logic [31:0] t_b [11];
    logic [31:0] t_exp [11];
    t_ctrl = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b101, 3'b101, 3'b100, 3'b110, 3'b111};
    t_a    = '{32'd5, 32'hFFFFFFFF, 32'd3, 32'hF0F0, 32'hF0F0, 32'hFFFFFFFF, 32'd1, 32'd7, 32'd5, 32'd5, 32'd5};
    t_b    = '{32'd7, 32'd1, 32'd5, 32'hFF00, 32'h0F0F, 32'd1, 32'hFFFFFFFF, 32'd7, 32'd3, 32'd3, 32'd3};
    t_exp  = '{32'd12, 32'd0, 32'hFFFFFFFE, 32'hF000, 32'hFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    set_idle();
    for (int i = 0; i < 11; i++) begin
      ex_valid = 1'b1; ex_alu_src = 1'b1; ex_branch = 1'b1;
      ex_alu_control = t_ctrl[i]; ex_rd1 = t_a[i]; ex_imm_ext = t_b[i];
      #1;
      n_cmp++; if (pc_src_e !== (t_exp[i] == 32'd0)) begin n_fail++; $display("FAIL alu_zero[%0d]: got %b exp %b", i, pc_src_e, (t_exp[i] == 32'd0)); end
      tick();
      n_cmp++; if (mem_alu_result !== t_exp[i]) begin n_fail++; $display("FAIL alu_result[%0d]: got %h exp %h", i, mem_alu_result, t_exp[i]); end
    end
  endtask

  task automatic test_stall();
    set_idle();
    ex_valid = 1'b1; ex_rd1 = 32'd10; ex_imm_ext = 32'd20; ex_alu_src = 1'b1; ex_rd = 5'd7; ex_reg_write = 1'b1;
    tick();
    n_cmp++; if (mem_alu_result !== 32'd30) begin n_fail++; $display("FAIL stall_capture: got %h exp 1e", mem_alu_result); end
    for (int i = 0; i < 3; i++) begin
      stall_m = 1'b1; ex_rd1 = 32'd1000 + i; ex_rd = 5'd9; ex_reg_write = 1'b0; ex_valid = (i != 1);
      ex_pc = 32'h200;
      #1;
      n_cmp++; if (pc_target_e !== 32'h214) begin n_fail++; $display("FAIL stall_pc_target[%0d]: got %h exp 214", i, pc_target_e); end
      tick();
      n_cmp++; if (mem_alu_result !== 32'd30) begin n_fail++; $display("FAIL stall_hold_alu[%0d]: got %h exp 1e", i, mem_alu_result); end
      n_cmp++; if (mem_rd !== 5'd7) begin n_fail++; $display("FAIL stall_hold_rd[%0d]: got %h exp 7", i, mem_rd); end
      n_cmp++; if (mem_reg_write !== 1'b1) begin n_fail++; $display("FAIL stall_hold_rw[%0d]: got %b exp 1", i, mem_reg_write); end
    end
    stall_m = 1'b0; ex_valid = 1'b1; ex_rd1 = 32'd100; ex_imm_ext = 32'd1;
    tick();
    n_cmp++; if (mem_alu_result !== 32'd101) begin n_fail++; $display("FAIL stall_release: got %h exp 65", mem_alu_result); end
    n_cmp++; if (mem_rd !== 5'd9) begin n_fail++; $display("FAIL stall_release_rd: got %h exp 9", mem_rd); end
  endtask

  task automatic test_bubble();
    set_idle();
    ex_valid = 1'b0; ex_reg_write = 1'b1; ex_mem_write = 1'b1; ex_jump = 1'b1;
    ex_rd1 = 32'd4; ex_alu_src = 1'b1; ex_imm_ext = 32'd4; ex_rd = 5'd5; ex_pc_plus4 = 32'h44;
    #1;
    n_cmp++; if (pc_src_e !== 1'b0) begin n_fail++; $display("FAIL bubble_pc_src: got %b exp 0", pc_src_e); end
    tick();
    n_cmp++; if (mem_reg_write !== 1'b0) begin n_fail++; $display("FAIL bubble_reg_write: got %b exp 0", mem_reg_write); end
    n_cmp++; if (mem_mem_write !== 1'b0) begin n_fail++; $display("FAIL bubble_mem_write: got %b exp 0", mem_mem_write); end
    n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_valid: got %b exp 0", mem_valid); end
    n_cmp++; if (mem_alu_result !== 32'd0) begin n_fail++; $display("FAIL bubble_alu: got %h exp 0", mem_alu_result); end
    n_cmp++; if (mem_pc_plus4 !== 32'd0) begin n_fail++; $display("FAIL bubble_pc4: got %h exp 0", mem_pc_plus4); end
    ex_valid = 1'b1;
    #1;
    n_cmp++; if (pc_src_e !== 1'b1) begin n_fail++; $display("FAIL jump_pc_src: got %b exp 1", pc_src_e); end
  endtask

  task automatic test_reset_mid_stall();
    set_idle();
    ex_valid = 1'b1; ex_rd1 = 32'd5; ex_imm_ext = 32'd5; ex_alu_src = 1'b1; ex_rd = 5'd4;
    tick();
    n_cmp++; if (mem_alu_result !== 32'd10) begin n_fail++; $display("FAIL rms_capture: got %h exp a", mem_alu_result); end
    stall_m = 1'b1; reset = 1'b1;
    tick();
    n_cmp++; if (mem_alu_result !== 32'd0) begin n_fail++; $display("FAIL rms_clear_alu: got %h exp 0", mem_alu_result); end
    n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL rms_clear_valid: got %b exp 0", mem_valid); end
    reset = 1'b0;
    tick();
    n_cmp++; if (mem_rd !== 5'd0) begin n_fail++; $display("FAIL rms_still_held: got %h exp 0", mem_rd); end
    stall_m = 1'b0;
    tick();
    n_cmp++; if (mem_alu_result !== 32'd10) begin n_fail++; $display("FAIL rms_resume: got %h exp a", mem_alu_result); end
    n_cmp++; if (mem_rd !== 5'd4) begin n_fail++; $display("FAIL rms_resume_rd: got %h exp 4", mem_rd); end
  endtask

  task automatic test_back_to_back();
    set_idle();
    ex_valid = 1'b1; ex_rd1 = 32'd1; ex_imm_ext = 32'd2; ex_alu_src = 1'b1; ex_rd = 5'd1; ex_reg_write = 1'b1;
    tick();
    n_cmp++; if (mem_alu_result !== 32'd3) begin n_fail++; $display("FAIL b2b_0: got %h exp 3", mem_alu_result); end
    fwd_a = 2'b10; fwd_b = 2'b10; ex_imm_ext = 32'd4; ex_reg_write = 1'b0; ex_mem_write = 1'b1; ex_rd = 5'd2;
    tick();
    n_cmp++; if (mem_alu_result !== 32'd7) begin n_fail++; $display("FAIL b2b_1: got %h exp 7", mem_alu_result); end
    n_cmp++; if (mem_write_data !== 32'd3) begin n_fail++; $display("FAIL b2b_1_wdata: got %h exp 3", mem_write_data); end
    n_cmp++; if (mem_mem_write !== 1'b1) begin n_fail++; $display("FAIL b2b_1_mw: got %b exp 1", mem_mem_write); end
    n_cmp++; if (mem_reg_write !== 1'b0) begin n_fail++; $display("FAIL b2b_1_rw: got %b exp 0", mem_reg_write); end
    fwd_a = 2'b01; wb_result = 32'd100; ex_alu_src = 1'b0; ex_alu_control = 3'b001; ex_mem_write = 1'b0;
    tick();
    n_cmp++; if (mem_alu_result !== 32'd93) begin n_fail++; $display("FAIL b2b_2: got %h exp 5d", mem_alu_result); end
    n_cmp++; if (mem_write_data !== 32'd7) begin n_fail++; $display("FAIL b2b_2_wdata: got %h exp 7", mem_write_data); end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_add();
    test_forward_sub();
    test_alu_ops();
    test_stall();
    test_bubble();
    test_reset_mid_stall();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
